// File: rtl/ntt_stage_ctrl_pkg.sv
// Shared definitions for the NTT stage sequencer: default widths, butterfly
// mode encodings, FSM state type and the mode legality check.
package ntt_stage_ctrl_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int TW_W_DEF   = 7;
    localparam int BF_LAT_DEF = 4;
    localparam int STG_W_DEF  = 3;

    // {sel_0, sel_1, KD_mode}
    localparam logic [2:0] MODE_K_R2_NTT  = 3'b000;
    localparam logic [2:0] MODE_K_R4_NTT  = 3'b100;
    localparam logic [2:0] MODE_K_R4_INTT = 3'b110;
    localparam logic [2:0] MODE_K_R2_INTT = 3'b010;
    localparam logic [2:0] MODE_D_NTT     = 3'b001;
    localparam logic [2:0] MODE_D_INTT    = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // True for the six butterfly configurations compact_bf supports.
    function automatic logic mode_legal_f(input logic [2:0] mode);
        logic ok_s;
        case (mode)
            MODE_K_R2_NTT, MODE_K_R4_NTT, MODE_K_R4_INTT,
            MODE_K_R2_INTT, MODE_D_NTT, MODE_D_INTT: ok_s = 1'b1;
            default:                                 ok_s = 1'b0;
        endcase
        return ok_s;
    endfunction

endpackage

// File: rtl/ntt_wb_delay.sv
// Write-back delay line: carries the read strobe and address through the
// butterfly latency so the write lands exactly BF_LAT cycles after the read.
// Shifts every cycle, so hold bubbles travel through as invalid slots.
module ntt_wb_delay
    import ntt_stage_ctrl_pkg::*;
#(
    parameter int BF_LAT = BF_LAT_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_vld,
    output logic [ADDR_W-1:0] out_addr
);

    logic [BF_LAT-1:0] vld_q;
    logic [BF_LAT-1:0] vld_d;
    logic [ADDR_W-1:0] addr_q [BF_LAT];
    logic [ADDR_W-1:0] addr_d [BF_LAT];

    // Next contents: new entry at slot 0, everything else moves one slot on.
    always_comb begin
        vld_d[0]  = in_vld;
        addr_d[0] = in_addr;
        for (int i = 1; i < BF_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            addr_d[i] = addr_q[i-1];
        end
    end

    // Shift register storage, cleared on reset so no stale write survives an abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= {BF_LAT{1'b0}};
            for (int i = 0; i < BF_LAT; i++) begin
                addr_q[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
        end
    end

    assign out_vld  = vld_q[BF_LAT-1];
    assign out_addr = addr_q[BF_LAT-1];

endmodule

// File: rtl/ntt_stage_ctrl.sv
// NTT/INTT stage sequencer for compact_bf: issues one butterfly read per
// cycle over the four coefficient banks, generates twiddle addresses, and
// drains the butterfly pipeline between stages.
module ntt_stage_ctrl
    import ntt_stage_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int TW_W   = TW_W_DEF,
    parameter int BF_LAT = BF_LAT_DEF,
    parameter int STG_W  = STG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        cfg_mode,
    input  logic [STG_W-1:0]  cfg_stages,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              sel_0,
    output logic              sel_1,
    output logic              KD_mode,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [TW_W-1:0]   tw_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
);

    localparam int CNT_W = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BF_LAT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [STG_W-1:0]  STG_ONE  = STG_W'(1);
    localparam logic [STG_W-1:0]  STG_ZERO = {STG_W{1'b0}};
    localparam logic [STG_W-1:0]  STG_MAX  = {STG_W{1'b1}};
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_LAST = {ADDR_W{1'b1}};
    localparam logic [TW_W-1:0]   TW_ONE   = TW_W'(1);

    // Twiddle index for stage s: one ROM segment per stage, finer twiddle
    // granularity as the stage number grows.
    function automatic logic [TW_W-1:0] tw_addr_f(input logic [STG_W-1:0] s,
                                                  input logic [ADDR_W-1:0] idx);
        logic [TW_W-1:0] base_s;
        logic [TW_W-1:0] off_s;
        base_s = TW_ONE << s;
        off_s  = TW_W'(idx) >> (ADDR_W - int'(s));
        return base_s + off_s;
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [STG_W-1:0]  stg_q, stg_d;
    logic [STG_W-1:0]  nstg_q, nstg_d;
    logic [2:0]        mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [TW_W-1:0]   tw_addr_q, tw_addr_d;

    logic              start_ok_s;
    logic              accept_s;
    logic              issue_s;
    logic              last_idx_s;
    logic              last_stg_s;
    logic              drain_end_s;
    logic [STG_W-1:0]  first_stg_s;
    logic [STG_W-1:0]  cur_stg_s;
    logic [STG_W-1:0]  stg_step_s;

    assign start_ok_s  = start & mode_legal_f(cfg_mode) & (cfg_stages != STG_ZERO);
    assign accept_s    = (state_q == ST_IDLE) & start_ok_s;
    // A read may be issued on the accept cycle itself so the first read follows start directly.
    assign issue_s     = (accept_s | (state_q == ST_RUN)) & ~hold;
    assign last_idx_s  = (idx_q == IDX_LAST);
    assign drain_end_s = (cnt_q == CNT_LAST);
    // INTT (sel_1) walks the stages downwards.
    assign first_stg_s = cfg_mode[1] ? (cfg_stages - STG_ONE) : STG_ZERO;
    assign cur_stg_s   = accept_s ? first_stg_s : stg_q;
    assign last_stg_s  = mode_q[1] ? (stg_q == STG_ZERO) : (stg_q == (nstg_q - STG_ONE));
    assign stg_step_s  = mode_q[1] ? ((stg_q == STG_ZERO) ? stg_q : (stg_q - STG_ONE))
                                   : ((stg_q == STG_MAX)  ? stg_q : (stg_q + STG_ONE));

    // State and datapath registers; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            idx_q     <= {ADDR_W{1'b0}};
            stg_q     <= STG_ZERO;
            nstg_q    <= STG_ZERO;
            mode_q    <= 3'b000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= {ADDR_W{1'b0}};
            tw_addr_q <= {TW_W{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            stg_q     <= stg_d;
            nstg_q    <= nstg_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            tw_addr_q <= tw_addr_d;
        end
    end

    // Next-state logic: issue a full stage, drain the pipeline, then next stage or finish.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = accept_s ? ST_RUN : ST_IDLE;
            ST_RUN:   state_d = (issue_s && last_idx_s) ? ST_DRAIN : ST_RUN;
            ST_DRAIN: begin
                if (drain_end_s) begin
                    state_d = last_stg_s ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values: config latch, read issue, drain count, done/error pulses.
    always_comb begin
        mode_d    = mode_q;
        nstg_d    = nstg_q;
        stg_d     = stg_q;
        idx_d     = idx_q;
        cnt_d     = {CNT_W{1'b0}};
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        tw_addr_d = tw_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    mode_d = cfg_mode;
                    nstg_d = cfg_stages;
                    stg_d  = first_stg_s;
                    busy_d = 1'b1;
                end else begin
                    err_d  = start;
                end
            end
            ST_RUN: begin
                cnt_d = {CNT_W{1'b0}};
            end
            ST_DRAIN: begin
                if (drain_end_s) begin
                    stg_d = last_stg_s ? stg_q : stg_step_s;
                    cnt_d = {CNT_W{1'b0}};
                end else begin
                    stg_d = stg_q;
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
        // idx wraps to zero after the last butterfly, ready for the next stage.
        if (issue_s) begin
            rd_en_d   = 1'b1;
            rd_addr_d = idx_q;
            tw_addr_d = tw_addr_f(cur_stg_s, idx_q);
            idx_d     = idx_q + IDX_ONE;
        end else begin
            rd_en_d   = 1'b0;
        end
    end

    ntt_wb_delay #(
        .BF_LAT (BF_LAT),
        .ADDR_W (ADDR_W)
    ) u_wb_delay (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (rd_en_q),
        .in_addr  (rd_addr_q),
        .out_vld  (wr_en),
        .out_addr (wr_addr)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign cfg_err = err_q;
    assign sel_0   = mode_q[2];
    assign sel_1   = mode_q[1];
    assign KD_mode = mode_q[0];
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign tw_addr = tw_addr_q;

endmodule
